// File: rtl/msf_tx_if.sv
// msf_tx_if: bundle between the MSF transmitter, its stimulus source, the minute BRAM read port and the modulator.
interface msf_tx_if #(parameter int CNT_W = 17);
    logic             tx_enable;
    logic             msf_carrier_pulse;
    logic [CNT_W-1:0] msf_frequency;
    logic [CNT_W-1:0] tenth_len;
    logic [5:0]       minute_bram_addr;
    logic [1:0]       minute_bram_data;
    logic             carrier_on;
    logic [CNT_W-1:0] tx_carrier_counter;
    logic [5:0]       tx_second_counter;
    logic             second_start;
    logic             minute_start;

    modport master (
        output tx_enable, msf_carrier_pulse, msf_frequency, tenth_len, minute_bram_data,
        input  minute_bram_addr, carrier_on, tx_carrier_counter, tx_second_counter,
               second_start, minute_start
    );
    modport slave (
        input  tx_enable, msf_carrier_pulse, msf_frequency, tenth_len, minute_bram_data,
        output minute_bram_addr, carrier_on, tx_carrier_counter, tx_second_counter,
               second_start, minute_start
    );
endinterface

// File: rtl/msf_timecode_tx.sv
// msf_timecode_tx: counts carrier pulses into seconds/minutes and keys the carrier from per-second {A,B} bits.
// Define MSF_MINUTE_ID_EN to force the minute-identifier A bits (0111 1110) in seconds 52..59.
module msf_timecode_tx #(
    parameter int SECONDS_MINUTE = 59,
    parameter int CNT_W = 17
) (
    input logic clk,
    input logic rst,
    msf_tx_if.slave bus
);
    localparam int TW = CNT_W + 3;

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
    state_t state, state_nx;

    logic [TW-1:0]    t1, t2, t3, t5, cz, tl;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       sec;
    logic [1:0]       ab;
    logic             a_bit, off, wrap, last_sec, ss, ms, on;

    assign tl       = TW'(bus.tenth_len);
    assign cz       = TW'(cnt);
    assign wrap     = cnt >= bus.msf_frequency;
    assign last_sec = sec == 6'(SECONDS_MINUTE);

`ifdef MSF_MINUTE_ID_EN
    assign a_bit = (sec >= 6'd52 && sec <= 6'd59) ? (sec != 6'd52 && sec != 6'd59) : ab[1];
`else
    assign a_bit = ab[1];
`endif

    // second 0 carries the 500 ms minute marker; other seconds key the A/B slots
    assign off = (sec == 6'd0) ? (cz < t5)
               : (cz < t1) | (a_bit & (cz < t2)) | (ab[0] & (cz >= t2) & (cz < t3));

    assign bus.minute_bram_addr   = sec;
    assign bus.carrier_on         = on;
    assign bus.tx_carrier_counter = cnt;
    assign bus.tx_second_counter  = sec;
    assign bus.second_start       = ss;
    assign bus.minute_start       = ms;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = !bus.tx_enable ? IDLE
                 : (state == IDLE) ? SYNC
                 : (state == SYNC && bus.msf_carrier_pulse) ? RUN
                 : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1 <= '0;
            t2 <= '0;
            t3 <= '0;
            t5 <= '0;
        end else begin
            t1 <= tl;
            t2 <= tl << 1;
            t3 <= (tl << 1) + tl;
            t5 <= (tl << 2) + tl;
        end
    end

    // BRAM data lags the address by one clk, so this latch lands two clk after the second changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ab <= '0;
        else     ab <= bus.minute_bram_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sec <= '0;
            ss  <= 1'b0;
            ms  <= 1'b0;
            on  <= 1'b0;
        end else if (!bus.tx_enable) begin
            cnt <= '0;
            sec <= '0;
            ss  <= 1'b0;
            ms  <= 1'b0;
            on  <= 1'b0;
        end else begin
            ss <= 1'b0;
            ms <= 1'b0;
            on <= (state == RUN) && !off;
            if (state == SYNC && bus.msf_carrier_pulse) begin
                cnt <= '0;
                sec <= '0;
                ss  <= 1'b1;
                ms  <= 1'b1;
            end else if (state == RUN && bus.msf_carrier_pulse) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                if (wrap) begin
                    sec <= last_sec ? 6'd0 : sec + 6'd1;
                    ss  <= 1'b1;
                    ms  <= last_sec;
                end
            end
        end
    end
endmodule
